// File: rtl/i2c_xfer_sequencer.sv
// i2c_xfer_sequencer
// Breaks one host register read/write request into START / WRITE / READ / STOP
// commands for the byte-level I2C master engine. It also checks slave ACKs,
// times out a hung engine, and returns read data plus a status code on a
// single-cycle response.
// Build option I2C_RSTART_EN: when defined, a single repeated START separates
// the register-address phase from the read phase. When undefined, a STOP
// followed by a fresh START is issued there instead.

module i2c_xfer_sequencer #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_dev,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_err,
  output logic       eng_cmd_valid,
  output logic [2:0] eng_cmd,
  output logic [7:0] eng_wbyte,
  output logic       eng_mnack,
  input  logic       eng_cmd_ready,
  input  logic       eng_done,
  input  logic [7:0] eng_rbyte,
  input  logic       eng_ack
);

  typedef enum logic [3:0] {
    IDLE, START, DEV_W, REG, WDATA, RSTART, DEV_R, RDATA, STOP, RESP
  } state_t;

  localparam logic [2:0]  CMD_NONE     = 3'd0;
  localparam logic [2:0]  CMD_START    = 3'd1;
  localparam logic [2:0]  CMD_WRITE    = 3'd2;
  localparam logic [2:0]  CMD_READ     = 3'd3;
  localparam logic [2:0]  CMD_STOP     = 3'd4;
  localparam logic [1:0]  ERR_OK       = 2'd0;
  localparam logic [1:0]  ERR_NACK     = 2'd1;
  localparam logic [1:0]  ERR_TIMEOUT  = 2'd2;
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state;
  state_t      adv_state;
  logic        waiting;
  logic [15:0] tcnt;
  logic        rw;
  logic [6:0]  dev;
  logic [7:0]  reg_addr;
  logic [7:0]  wdata;
  logic [7:0]  rbyte;
  logic [1:0]  err;
  logic        write_nack;
`ifndef I2C_RSTART_EN
  logic        rs_second;
`endif

  // Where the sequence goes once the current command completes; a missing ACK
  // on any address/data byte short-circuits straight to STOP.
  function automatic state_t after_done(input state_t s, input logic ack, input logic is_read);
    case (s)
      START:   after_done = DEV_W;
      DEV_W:   after_done = ack ? REG : STOP;
      REG:     after_done = !ack ? STOP : (is_read ? RSTART : WDATA);
      WDATA:   after_done = STOP;
      RSTART:  after_done = DEV_R;
      DEV_R:   after_done = ack ? RDATA : STOP;
      RDATA:   after_done = STOP;
      default: after_done = RESP;
    endcase
  endfunction

  // Engine command opcode issued on entry to a state.
  function automatic logic [2:0] cmd_of(input state_t s);
    case (s)
      START:                    cmd_of = CMD_START;
      DEV_W, REG, WDATA, DEV_R: cmd_of = CMD_WRITE;
      RDATA:                    cmd_of = CMD_READ;
      STOP:                     cmd_of = CMD_STOP;
`ifdef I2C_RSTART_EN
      RSTART:                   cmd_of = CMD_START;
`else
      RSTART:                   cmd_of = CMD_STOP;
`endif
      default:                  cmd_of = CMD_NONE;
    endcase
  endfunction

  // Byte carried by a WRITE command; zero for every other command.
  function automatic logic [7:0] wbyte_of(input state_t s, input logic [6:0] d,
                                          input logic [7:0] r, input logic [7:0] w);
    case (s)
      DEV_W:   wbyte_of = {d, 1'b0};
      REG:     wbyte_of = r;
      WDATA:   wbyte_of = w;
      DEV_R:   wbyte_of = {d, 1'b1};
      default: wbyte_of = 8'h00;
    endcase
  endfunction

  assign adv_state  = after_done(state, eng_ack, rw);
  assign write_nack = ((state == DEV_W) || (state == REG) || (state == WDATA) ||
                       (state == DEV_R)) && !eng_ack;

  // Transaction FSM: each engine state alternates an ISSUE phase (command held
  // until accepted) and a WAIT phase (done awaited under the timeout counter).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      waiting       <= 1'b0;
      tcnt          <= 16'd0;
      rw            <= 1'b0;
      dev           <= 7'd0;
      reg_addr      <= 8'h00;
      wdata         <= 8'h00;
      rbyte         <= 8'h00;
      err           <= ERR_OK;
      req_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= 8'h00;
      rsp_err       <= ERR_OK;
      eng_cmd_valid <= 1'b0;
      eng_cmd       <= CMD_NONE;
      eng_wbyte     <= 8'h00;
      eng_mnack     <= 1'b0;
`ifndef I2C_RSTART_EN
      rs_second     <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      rsp_err   <= ERR_OK;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            rw            <= req_rw;
            dev           <= req_dev;
            reg_addr      <= req_reg;
            wdata         <= req_wdata;
            rbyte         <= 8'h00;
            err           <= ERR_OK;
            req_ready     <= 1'b0;
            waiting       <= 1'b0;
            state         <= START;
            eng_cmd_valid <= 1'b1;
            eng_cmd       <= CMD_START;
            eng_wbyte     <= 8'h00;
            eng_mnack     <= 1'b0;
`ifndef I2C_RSTART_EN
            rs_second     <= 1'b0;
`endif
          end
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          if (!waiting) begin
            if (eng_cmd_ready) begin
              eng_cmd_valid <= 1'b0;
              eng_cmd       <= CMD_NONE;
              eng_wbyte     <= 8'h00;
              eng_mnack     <= 1'b0;
              waiting       <= 1'b1;
              tcnt          <= 16'd0;
            end
          end else if (eng_done) begin
            waiting <= 1'b0;
            if (state == RDATA) rbyte <= eng_rbyte;
            if (write_nack) err <= ERR_NACK;
            if (state == STOP) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= err;
              rsp_rdata <= (rw && (err == ERR_OK)) ? rbyte : 8'h00;
            end
`ifndef I2C_RSTART_EN
            else if ((state == RSTART) && !rs_second) begin
              rs_second     <= 1'b1;
              eng_cmd_valid <= 1'b1;
              eng_cmd       <= CMD_START;
            end
`endif
            else begin
              state         <= adv_state;
              eng_cmd_valid <= 1'b1;
              eng_cmd       <= cmd_of(adv_state);
              eng_wbyte     <= wbyte_of(adv_state, dev, reg_addr, wdata);
              eng_mnack     <= (adv_state == RDATA);
            end
          end else if (tcnt == TIMEOUT_LAST) begin
            waiting   <= 1'b0;
            state     <= RESP;
            err       <= ERR_TIMEOUT;
            rsp_valid <= 1'b1;
            rsp_err   <= ERR_TIMEOUT;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_xfer_sequencer.sv
// tb_i2c_xfer_sequencer
// Randomized bench for i2c_xfer_sequencer with a behavioural engine model and
// a transaction-level reference of the expected command stream and response.
// The reference follows I2C_RSTART_EN the same way the design build does.

module tb_i2c_xfer_sequencer;

  localparam int TO = 8;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_rw;
  logic [6:0] req_dev;
  logic [7:0] req_reg;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err;
  logic       eng_cmd_valid;
  logic [2:0] eng_cmd;
  logic [7:0] eng_wbyte;
  logic       eng_mnack;
  logic       eng_cmd_ready;
  logic       eng_done;
  logic [7:0] eng_rbyte;
  logic       eng_ack;

  int assert_count = 0;
  int fail_count   = 0;
  int cyc          = 0;

  // knobs shared with the engine model
  int         nack_w      = 99;
  int         hang_idx    = 99;
  int         done_delay  = -1;
  bit         force_stall = 1'b0;
  logic [7:0] cur_rbyte   = 8'h00;
  int         cmd_count   = 0;
  int         wr_ord      = 0;
  int         hang_cyc    = 0;

  // commands packed as {mnack, cmd[2:0], wbyte[7:0]}
  logic [11:0] exp_q[$];
  logic [11:0] act_q[$];
  logic [1:0]  exp_err;
  logic [7:0]  exp_rdata;

  i2c_xfer_sequencer #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .eng_cmd_valid(eng_cmd_valid), .eng_cmd(eng_cmd), .eng_wbyte(eng_wbyte),
    .eng_mnack(eng_mnack), .eng_cmd_ready(eng_cmd_ready), .eng_done(eng_done),
    .eng_rbyte(eng_rbyte), .eng_ack(eng_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] pk(input logic m, input logic [2:0] c, input logic [7:0] b);
    return {m, c, b};
  endfunction

  // Reference: the command list and response implied by the request, the
  // ordinal of the WRITE that is NACKed, and the index of the command whose
  // done never arrives.
  function automatic void build_expect(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                                       input logic [7:0] wd, input logic [7:0] rb,
                                       input int nk, input int hg);
    logic [7:0] wl[$];
    int  wn;
    bit  nacked;
    wn = 0;
    nacked = 1'b0;
    exp_q.delete();
    exp_q.push_back(pk(1'b0, 3'd1, 8'h00));
    wl.push_back({dev, 1'b0});
    wl.push_back(rg);
    if (!rw) wl.push_back(wd);
    for (int i = 0; i < wl.size() && !nacked; i++) begin
      exp_q.push_back(pk(1'b0, 3'd2, wl[i]));
      if (wn == nk) nacked = 1'b1;
      wn++;
    end
    if (rw && !nacked) begin
`ifndef I2C_RSTART_EN
      exp_q.push_back(pk(1'b0, 3'd4, 8'h00));
`endif
      exp_q.push_back(pk(1'b0, 3'd1, 8'h00));
      exp_q.push_back(pk(1'b0, 3'd2, {dev, 1'b1}));
      if (wn == nk) nacked = 1'b1;
      else exp_q.push_back(pk(1'b1, 3'd3, 8'h00));
    end
    exp_q.push_back(pk(1'b0, 3'd4, 8'h00));
    exp_err   = nacked ? 2'd1 : 2'd0;
    exp_rdata = (rw && !nacked) ? rb : 8'h00;
    if (hg < exp_q.size()) begin
      while (exp_q.size() > hg + 1) void'(exp_q.pop_back());
      exp_err   = 2'd2;
      exp_rdata = 8'h00;
    end
  endfunction

  // Engine model: random accept stalls, random done delay (up to the last
  // cycle the timeout allows), stray done pulses outside WAIT.
  initial begin
    int          stall;
    int          dly;
    int          idx;
    bit          is_wr;
    bit          is_rd;
    logic        ack_now;
    logic [12:0] snap;
    int          opts[5];
    opts = '{0, 1, 2, 3, TO - 1};
    eng_cmd_ready = 1'b0;
    eng_done      = 1'b0;
    eng_ack       = 1'b0;
    eng_rbyte     = 8'h00;
    forever begin
      @(negedge clk);
      eng_done      = 1'b0;
      eng_cmd_ready = 1'b0;
      if (rst && eng_cmd_valid) begin
        stall = (force_stall && cmd_count == 1) ? 5 : $urandom_range(0, 2);
        snap  = {eng_cmd_valid, eng_mnack, eng_cmd, eng_wbyte};
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          checkOutput("cmd_hold", {19'd0, eng_cmd_valid, eng_mnack, eng_cmd, eng_wbyte}, {19'd0, snap});
        end
        eng_cmd_ready = 1'b1;
        idx = cmd_count;
        cmd_count++;
        act_q.push_back({eng_mnack, eng_cmd, eng_wbyte});
        is_wr   = (eng_cmd == 3'd2);
        is_rd   = (eng_cmd == 3'd3);
        ack_now = !(is_wr && wr_ord == nack_w);
        if (is_wr) wr_ord++;
        if (idx == hang_idx) hang_cyc = cyc;
        if ($urandom_range(0, 3) == 0) begin
          eng_done  = 1'b1;
          eng_ack   = 1'b0;
          eng_rbyte = 8'($urandom);
        end
        @(negedge clk);
        eng_cmd_ready = 1'b0;
        eng_done      = 1'b0;
        if (idx != hang_idx) begin
          dly = (done_delay >= 0) ? done_delay : opts[$urandom_range(0, 4)];
          repeat (dly) @(negedge clk);
          eng_done  = 1'b1;
          eng_ack   = ack_now;
          eng_rbyte = is_rd ? cur_rbyte : 8'($urandom);
        end
      end
    end
  end

  // Command payload must be zero whenever no command is offered.
  always @(negedge clk) begin
    if (!eng_cmd_valid) begin
      checkOutput("idle_wbyte", {24'd0, eng_wbyte}, 32'd0);
      checkOutput("idle_mnack", {31'd0, eng_mnack}, 32'd0);
    end
  end

  task automatic start_request(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                               input logic [7:0] wd);
    int n;
    act_q.delete();
    cmd_count = 0;
    wr_ord    = 0;
    for (n = 0; n < 50 && !req_ready; n++) @(negedge clk);
    checkOutput("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_rw    = rw;
    req_dev   = dev;
    req_reg   = rg;
    req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    req_rw    = 1'($urandom);
    req_dev   = 7'($urandom);
    req_reg   = 8'($urandom);
    req_wdata = 8'($urandom);
    checkOutput("req_ready_drop", {31'd0, req_ready}, 32'd0);
    checkOutput("start_valid", {31'd0, eng_cmd_valid}, 32'd1);
    checkOutput("start_cmd", {29'd0, eng_cmd}, 32'd1);
  endtask

  task automatic applyStimulus(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                               input logic [7:0] wd, input logic [7:0] rb, input int nk,
                               input int hg, input int dd, input bit st);
    int n;
    int rsp_cyc;
    nack_w      = nk;
    hang_idx    = hg;
    done_delay  = dd;
    force_stall = st;
    cur_rbyte   = rb;
    build_expect(rw, dev, rg, wd, rb, nk, hg);
    start_request(rw, dev, rg, wd);
    for (n = 0; n < 600 && !rsp_valid; n++) @(negedge clk);
    if (!rsp_valid) begin
      checkOutput("rsp_arrives", 32'd0, 32'd1);
      return;
    end
    rsp_cyc = cyc;
    checkOutput("rsp_err", {30'd0, rsp_err}, {30'd0, exp_err});
    checkOutput("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, exp_rdata});
    checkOutput("cmd_count", act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      checkOutput($sformatf("cmd[%0d]", i), {20'd0, act_q[i]}, {20'd0, exp_q[i]});
    if (exp_err == 2'd2)
      checkOutput("timeout_latency", rsp_cyc - hang_cyc, TO + 1);
    @(negedge clk);
    checkOutput("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
    checkOutput("req_ready_back", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    int n;
    bit seen;
    rst       = 1'b0;
    req_valid = 1'b0;
    req_rw    = 1'b0;
    req_dev   = 7'd0;
    req_reg   = 8'h00;
    req_wdata = 8'h00;
    @(negedge clk);
    checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
    checkOutput("rst_rsp_err", {30'd0, rsp_err}, 32'd0);
    checkOutput("rst_cmd_valid", {31'd0, eng_cmd_valid}, 32'd0);
    checkOutput("rst_cmd", {29'd0, eng_cmd}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] directed: write, read, nack on reg, start timeout, long stall");
    applyStimulus(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, 99, 99, 3, 1'b0);
    applyStimulus(1'b1, 7'h50, 8'h22, 8'h00, 8'h3C, 99, 99, -1, 1'b0);
    applyStimulus(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, 1, 99, -1, 1'b0);
    applyStimulus(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, 99, 0, -1, 1'b0);
    applyStimulus(1'b0, 7'h50, 8'h33, 8'h5A, 8'h00, 99, 99, TO - 1, 1'b1);
    applyStimulus(1'b1, 7'h21, 8'h44, 8'h00, 8'h99, 2, 99, -1, 1'b0);

    $display("[TB] directed: reset during REG wait");
    nack_w      = 99;
    hang_idx    = 2;
    done_delay  = -1;
    force_stall = 1'b0;
    start_request(1'b0, 7'h50, 8'h10, 8'hA5);
    for (n = 0; n < 100 && cmd_count < 3; n++) @(negedge clk);
    checkOutput("reg_cmd_reached", cmd_count, 3);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("mid_rst_cmd_valid", {31'd0, eng_cmd_valid}, 32'd0);
    checkOutput("mid_rst_cmd", {29'd0, eng_cmd}, 32'd0);
    checkOutput("mid_rst_wbyte", {24'd0, eng_wbyte}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    checkOutput("no_rsp_after_reset", {31'd0, seen}, 32'd0);
    applyStimulus(1'b1, 7'h50, 8'h22, 8'h00, 8'hC3, 99, 99, -1, 1'b0);

    $display("[TB] randomized transactions");
    for (int t = 0; t < 40; t++) begin
      int nk;
      int hg;
      nk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : 99;
      hg = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7)) : 99;
      applyStimulus(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                    nk, hg, -1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
